// File: rtl/led_shift_ctrl.sv
// LED pattern stepper driven by edges of a sampled divided clock.
// Optional LED_BAR_EN turns mode 00 from hold into a bar-fill pattern.
module led_shift_ctrl #(
  parameter int LED_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             step_tick,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  localparam logic [LED_W-1:0] ONE = LED_W'(1);

  dir_t             dir_q;
  dir_t             dir_d;
  logic             div_q;
  logic             tick;
  logic             hold_mode;
  logic             adv;
  logic             one_hot;
  logic [LED_W-1:0] nxt;

  assign tick = clk_div & ~div_q;

`ifdef LED_BAR_EN
  assign hold_mode = 1'b0;
`else
  assign hold_mode = (mode == 2'b00);
`endif

  assign adv     = tick & en & ~hold_mode;
  assign one_hot = (led != '0) &&
                   ((led & (led - ONE)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= LEFT;
    end else begin
      dir_q <= dir_d;
    end
  end

  // next pattern and direction, only acted on during an advance
  always_comb begin
    nxt   = led;
    dir_d = dir_q;
    if (adv) begin
      unique case (1'b1)
        (mode == 2'b01): begin
          if (led == '0) nxt = ONE;
          else nxt = {led[LED_W-2:0], led[LED_W-1]};
        end
        (mode == 2'b10): begin
          if (led == '0) nxt = ONE;
          else nxt = {led[0], led[LED_W-1:1]};
        end
        (mode == 2'b11): begin
          if (!one_hot) begin
            nxt   = ONE;
            dir_d = LEFT;
          end else begin
            unique case (dir_q)
              LEFT: begin
                if (led[LED_W-1]) begin
                  nxt   = led >> 1;
                  dir_d = RIGHT;
                end else begin
                  nxt = led << 1;
                end
              end
              RIGHT: begin
                if (led[0]) begin
                  nxt   = led << 1;
                  dir_d = LEFT;
                end else begin
                  nxt = led >> 1;
                end
              end
            endcase
          end
        end
        (mode == 2'b00): begin
`ifdef LED_BAR_EN
          if (&led) nxt = '0;
          else nxt = (led << 1) | ONE;
`else
          nxt = led;
`endif
        end
      endcase
    end
  end

  // div_q resets high so clk_div already high at release is not a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 1'b1;
      led       <= ONE;
      step_tick <= 1'b0;
      step_cnt  <= '0;
    end else begin
      div_q     <= clk_div;
      step_tick <= adv;
      if (adv) begin
        led      <= nxt;
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Randomized bench for led_shift_ctrl with a position-based model
// and a few literal checkpoints.
module tb_led_shift_ctrl;

  localparam int W = 16;
  localparam int C = 8;
`ifdef LED_BAR_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_div = 1'b1;
  logic         en = 1'b1;
  logic [1:0]   mode = 2'b01;
  logic [W-1:0] led;
  logic         step_tick;
  logic [C-1:0] step_cnt;

  int vectors = 0;
  int miscompares = 0;

  led_shift_ctrl #(.LED_W(W), .CNT_W(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_div(clk_div),
    .en(en),
    .mode(mode),
    .led(led),
    .step_tick(step_tick),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // model state: lit position-based pattern, dir 0=left 1=right
  logic [W-1:0] m_led;
  logic         m_dir;
  logic         m_q;
  logic         m_tick;
  logic [C-1:0] m_cnt;
  logic [W:0]   m_nx;
  logic         m_adv;

  function automatic logic [W:0] mnext(
    input logic [W-1:0] v,
    input logic         d,
    input logic [1:0]   m
  );
    int pos;
    logic [W-1:0] r;
    pos = 0;
    for (int i = 0; i < W; i++) if (v[i]) pos = i;
    case (m)
      2'd1: begin
        if (v == 0) return {d, 16'h0001};
        r = (v << 1) | (v >> (W - 1));
        return {d, r};
      end
      2'd2: begin
        if (v == 0) return {d, 16'h0001};
        r = (v >> 1) | (v << (W - 1));
        return {d, r};
      end
      2'd3: begin
        if ($countones(v) != 1) return {1'b0, 16'h0001};
        if (!d) begin
          if (pos == W - 1) return {1'b1, 16'(1 << (W - 2))};
          return {1'b0, 16'(1 << (pos + 1))};
        end
        if (pos == 0) return {1'b0, 16'h0002};
        return {1'b1, 16'(1 << (pos - 1))};
      end
      default: begin
        if (!BAR) return {d, v};
        if (v == 16'hFFFF) return {d, 16'h0000};
        r = (v << 1) | 16'h0001;
        return {d, r};
      end
    endcase
  endfunction

  assign m_nx  = mnext(m_led, m_dir, mode);
  assign m_adv = clk_div & ~m_q & en & ((mode != 2'b00) | BAR);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led  <= 16'h0001;
      m_dir  <= 1'b0;
      m_q    <= 1'b1;
      m_tick <= 1'b0;
      m_cnt  <= '0;
    end else begin
      m_q    <= clk_div;
      m_tick <= m_adv;
      if (m_adv) begin
        m_led <= m_nx[W-1:0];
        m_dir <= m_nx[W];
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (led !== m_led || step_tick !== m_tick ||
        step_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL cycle t=%0t led=%h/%h tick=%b/%b cnt=%0d/%0d (got/exp)",
               $time, led, m_led, step_tick, m_tick,
               step_cnt, m_cnt);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // called just after a negedge with clk_div low
  task automatic pulse(input int hi, input int lo);
    clk_div = 1'b1;
    repeat (hi) @(negedge clk);
    #1;
    clk_div = 1'b0;
    repeat (lo) @(negedge clk);
    #1;
  endtask

  task automatic rpulse();
    pulse($urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_div = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_led", led, 16'h0001);
    chk("reset_cnt", step_cnt, 0);
    chk("reset_tick", step_tick, 0);
    clk_div = 1'b0;
    @(negedge clk);
    #1;

    mode = 2'b01;
    for (int i = 0; i < 16; i++) begin
      rpulse();
      if (i == 0) chk("rotl_first", led, 16'h0002);
      if (i == 14) chk("rotl_msb", led, 16'h8000);
    end
    chk("rotl_wrap", led, 16'h0001);
    chk("rotl_cnt", step_cnt, 16);

    mode = 2'b11;
    for (int i = 0; i < 31; i++) begin
      rpulse();
      if (i == 14) chk("pp_top", led, 16'h8000);
      if (i == 15) chk("pp_back", led, 16'h4000);
      if (i == 29) chk("pp_bottom", led, 16'h0001);
    end
    chk("pp_turn", led, 16'h0002);

    do_reset();
    mode = 2'b01;
    repeat (4) rpulse();
    chk("en_start", led, 16'h0010);
    en = 1'b0;
    repeat (3) rpulse();
    chk("en_hold_led", led, 16'h0010);
    chk("en_hold_cnt", step_cnt, 4);
    en = 1'b1;
    rpulse();
    chk("en_resume", led, 16'h0020);

    do_reset();
    repeat (202) pulse(1, 1);
    chk("pre_rst_led", led, 16'h0400);
    chk("pre_rst_cnt", step_cnt, 202);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    chk("async_led", led, 16'h0001);
    chk("async_cnt", step_cnt, 0);
    #5;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    repeat (255) pulse(1, 1);
    chk("cnt_255", step_cnt, 255);
    pulse(1, 1);
    chk("cnt_wrap", step_cnt, 0);

    do_reset();
    mode = 2'b00;
    if (!BAR) begin
      repeat (3) rpulse();
      chk("hold_led", led, 16'h0001);
      chk("hold_cnt", step_cnt, 0);
    end else begin
      rpulse();
      chk("bar_first", led, 16'h0003);
      repeat (14) rpulse();
      chk("bar_full", led, 16'hFFFF);
      rpulse();
      chk("bar_empty", led, 16'h0000);
      mode = 2'b11;
      rpulse();
      chk("pp_entry", led, 16'h0001);
    end

    for (int i = 0; i < 400; i++) begin
      mode = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      clk_div = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
      mode = 2'($urandom_range(0, 3));
      clk_div = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
